// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider.
// Each channel toggles clk_out every H = max(half,1) input cycles and pulses tick
// on the rising edge of its divided clock. Half-period updates are staged in a
// per-channel pending register and committed at the next toggle boundary, on the
// next cycle while the channel is stopped, or on a global sync, so a running
// output never sees a truncated half-period.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no staged half-period; channel accepts a new config
//   ST_PEND | new half-period held in pend_half_q, waiting for a boundary
module clock_divider_multi #(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 16,
  parameter int DEFAULT_HALF = 15,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [NUM_CH-1:0] enable,
  input  logic              sync_in,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } ch_state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);

  ch_state_t         state_q     [NUM_CH];
  ch_state_t         state_d     [NUM_CH];
  logic [CNT_W-1:0]  cnt_q       [NUM_CH];
  logic [CNT_W-1:0]  half_q      [NUM_CH];
  logic [CNT_W-1:0]  pend_half_q [NUM_CH];
  logic [CNT_W-1:0]  h_eff       [NUM_CH];
  logic [NUM_CH-1:0] clk_q;
  logic [NUM_CH-1:0] tick_q;
  logic [NUM_CH-1:0] ch_hit;
  logic [NUM_CH-1:0] term_cnt;
  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] apply;

  // Channel decode and terminal-count detect; a programmed 0 acts as 1
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_hit[i]   = ({1'b0, cfg_ch} == i[CH_W:0]);
      h_eff[i]    = (half_q[i] == '0) ? CNT_ONE : half_q[i];
      term_cnt[i] = enable[i] && (cnt_q[i] == (h_eff[i] - CNT_ONE));
    end
  end

  // State register
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!reset) state_q[i] <= ST_IDLE;
      else        state_q[i] <= state_d[i];
    end
  end

  // Next-state logic
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_IDLE: if (accept[i]) state_d[i] = ST_PEND;
        ST_PEND: if (apply[i])  state_d[i] = ST_IDLE;
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  // Output decode: ready is independent of cfg_valid; out-of-range channels are always ready
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_hit[i] && (state_q[i] == ST_PEND)) cfg_ready = 1'b0;
      accept[i] = cfg_valid && ch_hit[i] && (state_q[i] == ST_IDLE);
      apply[i]  = (state_q[i] == ST_PEND) && (sync_in || !enable[i] || term_cnt[i]);
    end
  end

  // Per-channel counters, divided clocks, ticks and half-period registers
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!reset) begin
        cnt_q[i]       <= '0;
        clk_q[i]       <= 1'b0;
        tick_q[i]      <= 1'b0;
        half_q[i]      <= HALF_RST;
        pend_half_q[i] <= HALF_RST;
      end else begin
        tick_q[i] <= 1'b0;
        if (accept[i]) pend_half_q[i] <= cfg_half;
        if (apply[i])  half_q[i]      <= pend_half_q[i];
        if (sync_in) begin
          cnt_q[i] <= '0;
          clk_q[i] <= 1'b0;
        end else if (enable[i]) begin
          if (term_cnt[i]) begin
            cnt_q[i]  <= '0;
            clk_q[i]  <= ~clk_q[i];
            tick_q[i] <= ~clk_q[i];
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_ONE;
          end
        end
      end
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed plus randomized bench for clock_divider_multi with a queue-based
// reference model of each channel (position in half-period, level, staged halves).
module tb_clock_divider_multi;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 16;
  localparam int DEF_H  = 15;
  localparam int CH_W   = 2;

  logic              clk_in;
  logic              reset;
  logic [NUM_CH-1:0] enable;
  logic              sync_in;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_half;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  clock_divider_multi #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_HALF(DEF_H)
  ) dut (
    .clk_in(clk_in), .reset(reset), .enable(enable), .sync_in(sync_in),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_half(cfg_half), .clk_out(clk_out), .tick(tick)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  // Reference model
  int m_half [NUM_CH];
  int m_pos  [NUM_CH];
  bit m_lvl  [NUM_CH];
  bit m_tick [NUM_CH];
  int m_pend [NUM_CH][$];

  function automatic bit m_ready(int ch);
    return (ch >= NUM_CH) || (m_pend[ch].size() == 0);
  endfunction

  function automatic void m_apply(int i);
    if (m_pend[i].size() > 0) m_half[i] = m_pend[i].pop_front();
  endfunction

  function automatic void m_update();
    bit acc;
    int h;
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_half[i] = DEF_H; m_pos[i] = 0; m_lvl[i] = 0; m_tick[i] = 0;
        m_pend[i].delete();
      end
    end else begin
      acc = cfg_valid && (int'(cfg_ch) < NUM_CH) && m_ready(int'(cfg_ch));
      for (int i = 0; i < NUM_CH; i++) begin
        h = (m_half[i] == 0) ? 1 : m_half[i];
        m_tick[i] = 0;
        if (sync_in) begin
          m_apply(i); m_pos[i] = 0; m_lvl[i] = 0;
        end else if (enable[i]) begin
          if (m_pos[i] == h - 1) begin
            m_lvl[i] = !m_lvl[i]; m_tick[i] = m_lvl[i]; m_pos[i] = 0; m_apply(i);
          end else begin
            m_pos[i]++;
          end
        end else begin
          m_apply(i);
        end
      end
      if (acc) m_pend[int'(cfg_ch)].push_back(int'(cfg_half));
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One input cycle: inputs already driven at the falling edge
  task automatic step();
    #1;
    chk("cfg_ready", 32'(cfg_ready), 32'(m_ready(int'(cfg_ch))));
    @(posedge clk_in);
    m_update();
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      chk("clk_out", 32'(clk_out[i]), 32'(m_lvl[i]));
      chk("tick", 32'(tick[i]), 32'(m_tick[i]));
    end
    @(negedge clk_in);
  endtask

  function automatic bit any_pend();
    for (int i = 0; i < NUM_CH; i++) if (m_pend[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit lvl;
    reset = 1'b0; enable = '1; sync_in = 1'b0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_half = '0;
    @(negedge clk_in);

    // 1: reset then default divide-by-30
    for (int c = 0; c < 3; c++) step();
    chk("rst_clk_out", 32'(clk_out), 32'(0));
    chk("rst_tick", 32'(tick), 32'(0));
    reset = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      step();
      chk("t1_tick0", 32'(tick[0]), 32'((c == 15) || (c == 45)));
      chk("t1_clk0", 32'(clk_out[0]), 32'(((c >= 15) && (c < 30)) || (c >= 45)));
    end

    // 2: mid-period reconfigure ch0 to half 3
    for (int c = 0; c < 5; c++) step();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 16'd3;
    #1 chk("t2_ready_idle", 32'(cfg_ready), 32'(1));
    step();

    // 3: ch0 busy, ch1 accepted, out-of-range channel accepted and ignored
    cfg_half = 16'd7;
    #1 chk("t3_ready_busy", 32'(cfg_ready), 32'(0));
    step();
    cfg_ch = 2'd1; cfg_half = 16'd12;
    step();
    cfg_ch = 2'd3; cfg_half = 16'd1;
    #1 chk("t3_ready_oor", 32'(cfg_ready), 32'(1));
    step();
    cfg_ch = 2'd0; cfg_half = 16'd7;
    n = 0;
    while (!m_ready(0) && n < 200) begin step(); n++; end
    chk("t3_hold_bound", 32'(n < 200), 32'(1));
    step();
    cfg_valid = 1'b0;

    // 4: freeze ch1 at cnt=5 for 7 cycles
    n = 0;
    while (!(m_pos[1] == 5 && m_half[1] == 12 && m_pend[1].size() == 0) && n < 200) begin
      step(); n++;
    end
    chk("t4_wait_bound", 32'(n < 200), 32'(1));
    lvl = clk_out[1];
    enable = 3'b101;
    for (int c = 0; c < 7; c++) begin
      step();
      chk("t4_frozen", 32'(clk_out[1]), 32'(lvl));
      chk("t4_tick_low", 32'(tick[1]), 32'(0));
    end
    enable = '1;
    n = 0;
    do begin step(); n++; end while (clk_out[1] == lvl && n < 40);
    chk("t4_resume", 32'(n), 32'(12 - 5));

    // 5: sync with ch0 pending half 4
    n = 0;
    while (!m_ready(0) && n < 200) begin step(); n++; end
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 16'd4;
    step();
    cfg_valid = 1'b0; sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    chk("t5_sync_clk", 32'(clk_out), 32'(0));
    n = 0;
    do begin step(); n++; end while (clk_out[0] == 1'b0 && n < 40);
    chk("t5_first_rise", 32'(n), 32'(4));

    // 6: half 0 on ch2 gives divide-by-2, then reset mid-run
    n = 0;
    while (!m_ready(2) && n < 200) begin step(); n++; end
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_half = 16'd0;
    step();
    cfg_valid = 1'b0;
    n = 0;
    while (!(m_half[2] == 0 && m_pend[2].size() == 0) && n < 100) begin step(); n++; end
    chk("t6_apply_bound", 32'(n < 100), 32'(1));
    for (int c = 0; c < 6; c++) begin
      lvl = clk_out[2];
      step();
      chk("t6_div2", 32'(clk_out[2]), 32'(!lvl));
    end
    reset = 1'b0;
    step();
    chk("t6_rst_clk", 32'(clk_out), 32'(0));
    chk("t6_rst_tick", 32'(tick), 32'(0));
    reset = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      step();
      chk("t6_default", 32'(clk_out), 32'((c == 15) ? 3'b111 : 3'b000));
    end

    // Random config traffic with occasional sync, all channels running
    for (int c = 0; c < 400; c++) begin
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_ch    = CH_W'($urandom_range(0, 3));
      cfg_half  = CNT_W'($urandom_range(0, 9));
      sync_in   = ($urandom_range(0, 39) == 0);
      step();
    end
    cfg_valid = 1'b0; sync_in = 1'b0;
    n = 0;
    while (any_pend() && n < 200) begin step(); n++; end
    chk("drain_bound", 32'(n < 200), 32'(1));

    // Random enable gating with no staged configs
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 3) == 0) enable = NUM_CH'($urandom_range(0, 7));
      sync_in = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
